// File: rtl/odometer_multi.sv
`default_nettype none
// ============================================================================
// Module   : odometer_multi
// Purpose  : Mileage recorder. It counts distance ticks while the drive FSM
//            sits in a state flagged as moving. It keeps a lifetime total and
//            a clearable trip count, both packed BCD (digit 0 in the LSBs).
//            An internal prescaler divides clk down to TICK_HZ.
// Options  : ODO_RETAIN_TOTAL_EN - when defined, power-off keeps total_bcd
//            and total_ovf, so the total behaves as a non-volatile odometer.
//            Only rst clears them in that build.
// Revision : 1.0 - initial release
// ============================================================================
module odometer_multi #(
    parameter int          CLK_HZ    = 100_000_000,
    parameter int          TICK_HZ   = 2,
    parameter int          DIGITS    = 8,
    parameter int          STATE_W   = 4,
    parameter logic [15:0] MOVE_MASK = 16'h0010
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  power_on,
    input  logic [STATE_W-1:0]    state,
    input  logic                  trip_clr,
    output logic [4*DIGITS-1:0]   total_bcd,
    output logic [4*DIGITS-1:0]   trip_bcd,
    output logic                  tick,
    output logic                  total_ovf
);

    // DIV must be at least 2. The prescaler is clog2(DIV) bits wide.
    localparam int              c_DIV     = CLK_HZ / TICK_HZ;
    localparam int              c_PS_W    = (c_DIV > 2) ? $clog2(c_DIV) : 1;
    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(c_DIV - 1);

    logic [c_PS_W-1:0]   presc_q, presc_d;
    logic                tick_q, tick_d;
    logic [4*DIGITS-1:0] total_q, total_d;
    logic [4*DIGITS-1:0] trip_q, trip_d;
    logic                ovf_q, ovf_d;

    logic [31:0]         w_state_ext;
    logic                w_moving;
    logic [4*DIGITS:0]   w_total_inc;   // {carry-out, incremented value}
    logic [4*DIGITS:0]   w_trip_inc;

    // Decimal +1 with a ripple carry through the digits.
    // The carry-out is 1 exactly when the input was all 9s.
    function automatic logic [4*DIGITS:0] bcd_inc(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    // State values of 16 and above are never moving, whatever the mask says.
    assign w_state_ext = 32'(state);
    assign w_moving    = power_on && (w_state_ext < 32'd16) && MOVE_MASK[w_state_ext[3:0]];
    assign w_total_inc = bcd_inc(total_q);
    assign w_trip_inc  = bcd_inc(trip_q);

    // Next-state logic. Power-off clears state. The counters advance on the
    // cycle after a registered tick, and trip_clr beats a coincident increment.
    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        total_d = total_q;
        trip_d  = trip_q;
        ovf_d   = ovf_q;
        if (!power_on) begin
            presc_d = '0;
            trip_d  = '0;
`ifdef ODO_RETAIN_TOTAL_EN
            total_d = total_q;
            ovf_d   = ovf_q;
`else
            total_d = '0;
            ovf_d   = 1'b0;
`endif
        end else begin
            if (tick_q) begin
                total_d = w_total_inc[4*DIGITS-1:0];
                trip_d  = w_trip_inc[4*DIGITS-1:0];
                if (w_total_inc[4*DIGITS]) begin
                    ovf_d = 1'b1;
                end
            end
            if (trip_clr) begin
                trip_d = '0;
            end
            // The prescaler freezes while stopped, so a partial interval resumes later.
            if (w_moving) begin
                if (presc_q == c_PS_LAST) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            total_q <= '0;
            trip_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            total_q <= total_d;
            trip_q  <= trip_d;
            ovf_q   <= ovf_d;
        end
    end

    assign total_bcd = total_q;
    assign trip_bcd  = trip_q;
    assign tick      = tick_q;
    assign total_ovf = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_odometer_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_odometer_multi
// Purpose  : Self-checking bench for odometer_multi (DIV=4, DIGITS=2). It uses
//            a decimal integer reference model and a scoreboard queue. An
//            independent monitor pops and compares the queue every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_odometer_multi;

    localparam int          c_DIV  = 4;
    localparam int          c_MOD  = 100;
    localparam logic [15:0] c_MASK = 16'h0010;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       power_on = 1'b0;
    logic [3:0] state = 4'd0;
    logic       trip_clr = 1'b0;
    logic [7:0] total_bcd, trip_bcd;
    logic       tick, total_ovf;

    always #5 clk = ~clk;

    odometer_multi #(
        .CLK_HZ   (8),
        .TICK_HZ  (2),
        .DIGITS   (2),
        .STATE_W  (4),
        .MOVE_MASK(c_MASK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .power_on (power_on),
        .state    (state),
        .trip_clr (trip_clr),
        .total_bcd(total_bcd),
        .trip_bcd (trip_bcd),
        .tick     (tick),
        .total_ovf(total_ovf)
    );

    typedef struct {
        logic [7:0] total;
        logic [7:0] trip;
        logic       tick;
        logic       ovf;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state: plain decimal integers and an interval phase.
    int   m_phase = 0;
    int   m_total = 0;
    int   m_trip  = 0;
    bit   m_tick  = 1'b0;
    bit   m_ovf   = 1'b0;

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    // Apply one cycle of inputs, advance the model and queue the expected outputs.
    task automatic step(input bit r, input bit p, input logic [3:0] s, input bit c);
        bit   mv;
        bit   upd;
        exp_t e;
        @(negedge clk);
        rst      = r;
        power_on = p;
        state    = s;
        trip_clr = c;
        mv  = p && c_MASK[s];
        upd = m_tick;
        if (!r) begin
            m_phase = 0; m_tick = 0; m_total = 0; m_trip = 0; m_ovf = 0;
        end else if (!p) begin
            m_phase = 0; m_tick = 0; m_trip = 0;
`ifndef ODO_RETAIN_TOTAL_EN
            m_total = 0; m_ovf = 0;
`endif
        end else begin
            if (upd) begin
                if (m_total == c_MOD - 1) m_ovf = 1;
                m_total = (m_total + 1) % c_MOD;
                m_trip  = (m_trip + 1) % c_MOD;
            end
            if (c) m_trip = 0;
            m_tick = 0;
            if (mv) begin
                m_phase = m_phase + 1;
                if (m_phase == c_DIV) begin
                    m_phase = 0;
                    m_tick  = 1;
                end
            end
        end
        e.total = to_bcd(m_total);
        e.trip  = to_bcd(m_trip);
        e.tick  = m_tick;
        e.ovf   = m_ovf;
        sbq.push_back(e);
    endtask

    // Monitor: compares the DUT outputs after each edge with the queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            vectors++;
            if (total_bcd !== e.total || trip_bcd !== e.trip ||
                tick !== e.tick || total_ovf !== e.ovf) begin
                miscompares++;
                $display("FAIL vec%0d @%0t: got total=%h trip=%h tick=%b ovf=%b, want total=%h trip=%h tick=%b ovf=%b",
                         vectors, $time, total_bcd, trip_bcd, tick, total_ovf,
                         e.total, e.trip, e.tick, e.ovf);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        // 1: reset, then 16 moving cycles -> four ticks, count 04.
        repeat (3) step(0, 1, 4'd4, 0);
        repeat (16) step(1, 1, 4'd4, 0);
        repeat (2) step(1, 1, 4'd0, 0);

        // 2: run the total up to 98, then cross 99 -> 00 and keep ticking.
        guard = 0;
        while (m_total != 98 && guard < 2000) begin
            step(1, 1, 4'd4, 0);
            guard++;
        end
        repeat (5 * c_DIV + 2) step(1, 1, 4'd4, 0);

        // 3: a partial interval is held across a stop.
        repeat (2) step(0, 1, 4'd4, 0);
        repeat (2) step(1, 1, 4'd4, 0);
        repeat (10) step(1, 1, 4'd2, 0);
        repeat (2) step(1, 1, 4'd4, 0);
        repeat (3) step(1, 1, 4'd2, 0);

        // 4: clear trip on the update cycle of the 6th tick.
        step(0, 1, 4'd4, 0);
        guard = 0;
        while (m_total != 6 && guard < 200) begin
            step(1, 1, 4'd4, (m_tick && m_trip == 5));
            guard++;
        end
        repeat (3) step(1, 1, 4'd0, 0);

        // 5: total at 07, drop power for one cycle, then restore.
        step(0, 1, 4'd4, 0);
        guard = 0;
        while (m_total != 7 && guard < 200) begin
            step(1, 1, 4'd4, 0);
            guard++;
        end
        step(1, 1, 4'd4, 0);
        step(1, 0, 4'd4, 0);
        repeat (c_DIV + 3) step(1, 1, 4'd4, 0);

        // 6: reset mid-interval; the first tick comes DIV cycles after release.
        step(1, 1, 4'd4, 0);
        step(0, 1, 4'd4, 0);
        repeat (2 * c_DIV + 2) step(1, 1, 4'd4, 0);

        // Randomized traffic: mostly powered, state biased to moving.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 1) != 0) ? 4'd4 : 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 29) == 0));
        end

        @(posedge clk);
        #2;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/odometer_multi.md
Name: odometer_multi

Overview:
- Parametrised mileage recorder for the car controller: counts distance ticks while the drive FSM is in any state flagged as moving.
- Keeps a lifetime total and a user-clearable trip counter, both packed BCD, for the 7-seg display driver.
- Has an internal tick prescaler, so no separate clock divider is needed.
- Sits beside the drive FSM and takes power and state from it.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- TICK_HZ, 2, distance increments per second while moving; DIV = CLK_HZ/TICK_HZ, must be >= 2.
- DIGITS, 8, BCD digits per counter.
- STATE_W, 4, width of drive-state input.
- MOVE_MASK, 16'h0010, bit s set means state value s counts as moving. Default is manual-drive state 4'b0100.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-low.
- power_on  input  1  1 = car powered.
- state  input  STATE_W  current drive-FSM state.
- trip_clr  input  1  single-cycle pulse that clears the trip counter.
- total_bcd  output  4*DIGITS  lifetime distance, packed BCD, digit 0 in LSBs.
- trip_bcd  output  4*DIGITS  trip distance, packed BCD.
- tick  output  1  one-cycle pulse on each distance increment.
- total_ovf  output  1  sticky: set when total wraps past all-9s.

Behaviour:
- Everything is registered on posedge clk.
- Reset: when rst=0, all of the following are 0: prescaler, total_bcd, trip_bcd, tick, total_ovf. Reset has priority over every other input.
- Moving: moving = power_on && MOVE_MASK[state].
  - If state >= 16, moving = 0.
- Power-off: power_on=0 behaves as reset for all state, except as modified by the optional feature.
- Prescaler: counter of width clog2(DIV).
  - While moving: increments each cycle. When it equals DIV-1, it returns to 0 and tick=1 on that same cycle's registered output.
  - While not moving but powered: holds its value, so partial intervals carry over across stops. It is not cleared.
- Counter update: on the cycle after tick=1, total_bcd and trip_bcd each become their value +1 in decimal. Latency from the prescaler terminal count to the visible count is 2 cycles.
- BCD arithmetic: ripple-carry per digit.
  - A digit holding 9 becomes 0 and carries into the next digit.
  - Non-BCD nibbles cannot occur.
- Total wrap: all-9s +1 gives all-0s, and total_ovf is set to 1 on that cycle. total_ovf stays 1 until reset or power-off.
- Trip wrap: trip wraps silently and has no flag.
- trip_clr:
  - trip_bcd becomes 0 on the next cycle.
  - If it coincides with a counter-update cycle, the clear wins: trip is 0, not 1. Total still increments.
  - trip_clr while not powered is ignored.
- State change mid-interval: the prescaler freezes at the first non-moving cycle. No increment occurs for a partial interval.
- tick is 0 whenever not moving.

Optional Feature:
- Macro: ODO_RETAIN_TOTAL_EN.
- Defined: power_on=0 clears the prescaler, trip_bcd and tick, but total_bcd and total_ovf hold their values. Only rst=0 clears them. This models a non-volatile odometer.
- Undefined: power_on=0 clears everything, as described in Behaviour.

Test Plan:
Bench parameters: CLK_HZ=8, TICK_HZ=2 (DIV=4), DIGITS=2, MOVE_MASK=16'h0010 unless stated otherwise.
1. rst=0 for 3 cycles, then rst=1, power_on=1, state=4 for 16 cycles -> tick pulses 4 times, every 4th cycle; total_bcd=8'h04 and trip_bcd=8'h04 two cycles after the 4th terminal count.
2. Moving with total preloaded to 8'h98 via ticks, then 2 more ticks -> total 8'h99 then 8'h00; total_ovf=1 and stays 1 through 3 further ticks.
3. state=4 for 2 cycles, state=2 for 10 cycles, state=4 for 2 cycles -> exactly one tick, at the 2nd cycle after resumption; tick=0 throughout state=2.
4. trip_bcd=8'h05, assert trip_clr on the same cycle the counter update for the 6th tick occurs -> trip_bcd=8'h00, total_bcd increments to 8'h06.
5. total=8'h07, drop power_on for 1 cycle, restore -> without ODO_RETAIN_TOTAL_EN: total=0, trip=0, prescaler restarts from 0. With the macro defined: total=8'h07, trip=0.
6. rst=0 asserted mid-interval while moving with power_on=1 -> all outputs 0 on the next edge; the first tick after release occurs exactly DIV cycles later.
